// File: rtl/uart_rx_fsm.sv
// Control FSM of the UART receiver: detects a start bit, sequences one frame
// (start, data, optional parity, stop) and drives the datapath enables.
module uart_rx_fsm #(
    parameter int DATA_WIDTH = 8
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       RX_IN,
    input  logic       PAR_EN,
    input  logic [5:0] prescale,
    input  logic [3:0] bit_cnt,
    input  logic [5:0] edge_cnt,
    input  logic       strt_glitch,
    input  logic       par_err,
    input  logic       stp_err,
    output logic       cnt_enable,
    output logic       reset_counters,
    output logic       dat_samp_en,
    output logic       deser_en,
    output logic       strt_chk_en,
    output logic       par_chk_en,
    output logic       stp_chk_en,
    output logic       data_valid,
    output logic       par_err_flag,
    output logic       stp_err_flag
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        VALID  = 3'd5
    } state_e;

    localparam logic [3:0] LastDataBit = 4'(DATA_WIDTH);

    state_e state_q, state_d;
    logic   parErrFlag_q, parErrFlag_d;
    logic   stpErrFlag_q, stpErrFlag_d;
    logic   lastEdge;

    assign lastEdge = (edge_cnt == (prescale - 6'd1));

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q      <= IDLE;
            parErrFlag_q <= 1'b0;
            stpErrFlag_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            parErrFlag_q <= parErrFlag_d;
            stpErrFlag_q <= stpErrFlag_d;
        end
    end

    // Flags are sticky across IDLE so software can inspect the last frame.
    always_comb begin
        state_d        = state_q;
        parErrFlag_d   = parErrFlag_q;
        stpErrFlag_d   = stpErrFlag_q;
        cnt_enable     = 1'b0;
        reset_counters = 1'b0;
        dat_samp_en    = 1'b0;
        deser_en       = 1'b0;
        strt_chk_en    = 1'b0;
        par_chk_en     = 1'b0;
        stp_chk_en     = 1'b0;
        data_valid     = 1'b0;

        case (state_q)
            IDLE: begin
                reset_counters = 1'b1;
                if (!RX_IN) begin
                    state_d = START;
                end
            end
            START: begin
                cnt_enable  = 1'b1;
                dat_samp_en = 1'b1;
                strt_chk_en = 1'b1;
                if (lastEdge) begin
                    if (strt_glitch) begin
                        state_d = IDLE;
                    end else begin
                        state_d      = DATA;
                        parErrFlag_d = 1'b0;
                        stpErrFlag_d = 1'b0;
                    end
                end
            end
            DATA: begin
                cnt_enable  = 1'b1;
                dat_samp_en = 1'b1;
                deser_en    = lastEdge;
                if (lastEdge && (bit_cnt == LastDataBit)) begin
                    state_d = PAR_EN ? PARITY : STOP;
                end
            end
            PARITY: begin
                cnt_enable  = 1'b1;
                dat_samp_en = 1'b1;
                par_chk_en  = 1'b1;
                if (lastEdge) begin
                    parErrFlag_d = par_err;
                    state_d      = STOP;
                end
            end
            STOP: begin
                cnt_enable  = 1'b1;
                dat_samp_en = 1'b1;
                stp_chk_en  = 1'b1;
                if (lastEdge) begin
                    stpErrFlag_d = stp_err;
                    state_d      = (stp_err || parErrFlag_q) ? IDLE : VALID;
                end
            end
            VALID: begin
                data_valid     = 1'b1;
                reset_counters = 1'b1;
                state_d        = RX_IN ? IDLE : START;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign par_err_flag = parErrFlag_q;
    assign stp_err_flag = stpErrFlag_q;

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Testbench for uart_rx_fsm: models the edge/bit counter and checks frame
// sequencing, error flags, back-to-back frames and asynchronous reset.
module tb_uart_rx_fsm;

    logic       CLK;
    logic       RST;
    logic       rxIn;
    logic       parEn;
    logic [5:0] prescale;
    logic [3:0] bitCnt;
    logic [5:0] edgeCnt;
    logic       strtGlitch;
    logic       parErr;
    logic       stpErr;
    logic       cnt_enable, reset_counters, dat_samp_en, deser_en;
    logic       strt_chk_en, par_chk_en, stp_chk_en, data_valid;
    logic       par_err_flag, stp_err_flag;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [5:0] prescale;
        logic       parEn;
        logic       glitch;
        logic       parErr;
        logic       stpErr;
        int         expDeser;
        int         expValidOff;
        int         expParChk;
        int         expStpChk;
        int         expParFlag;
        int         expStpFlag;
    } vec_t;

    vec_t vecs[8];

    uart_rx_fsm #(.DATA_WIDTH(8)) dut (
        .CLK            (CLK),
        .RST            (RST),
        .RX_IN          (rxIn),
        .PAR_EN         (parEn),
        .prescale       (prescale),
        .bit_cnt        (bitCnt),
        .edge_cnt       (edgeCnt),
        .strt_glitch    (strtGlitch),
        .par_err        (parErr),
        .stp_err        (stpErr),
        .cnt_enable     (cnt_enable),
        .reset_counters (reset_counters),
        .dat_samp_en    (dat_samp_en),
        .deser_en       (deser_en),
        .strt_chk_en    (strt_chk_en),
        .par_chk_en     (par_chk_en),
        .stp_chk_en     (stp_chk_en),
        .data_valid     (data_valid),
        .par_err_flag   (par_err_flag),
        .stp_err_flag   (stp_err_flag)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Behavioural model of the receiver's edge/bit counter.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            edgeCnt <= 6'd0;
            bitCnt  <= 4'd0;
        end else if (reset_counters) begin
            edgeCnt <= 6'd0;
            bitCnt  <= 4'd0;
        end else if (cnt_enable) begin
            if (edgeCnt == prescale - 6'd1) begin
                edgeCnt <= 6'd0;
                bitCnt  <= bitCnt + 4'd1;
            end else begin
                edgeCnt <= edgeCnt + 6'd1;
            end
        end
    end

    function automatic logic [9:0] outVec();
        return {cnt_enable, reset_counters, dat_samp_en, deser_en, strt_chk_en,
                par_chk_en, stp_chk_en, data_valid, par_err_flag, stp_err_flag};
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    task automatic applyStimulus(input logic rx, input logic pe, input logic [5:0] ps,
                                 input logic gl, input logic pErr, input logic sErr);
        rxIn       = rx;
        parEn      = pe;
        prescale   = ps;
        strtGlitch = gl;
        parErr     = pErr;
        stpErr     = sErr;
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic runFrame(input vec_t v, output int nDeser, output int firstDeser,
                            output int lastDeser, output int validOff, output int nValid,
                            output int nPar, output int nStp);
        int p;
        p = int'(v.prescale);
        nDeser = 0; firstDeser = -1; lastDeser = -1;
        validOff = -1; nValid = 0; nPar = 0; nStp = 0;
        applyStimulus(1'b1, v.parEn, v.prescale, v.glitch, v.parErr, v.stpErr);
        tick();
        rxIn = 1'b0;
        tick();
        for (int k = 0; k <= 11 * p + 3; k++) begin
            if (deser_en) begin
                nDeser++;
                if (firstDeser < 0) firstDeser = k;
                lastDeser = k;
            end
            if (data_valid) begin
                nValid++;
                if (validOff < 0) validOff = k;
            end
            if (par_chk_en) nPar++;
            if (stp_chk_en) nStp++;
            if (k == 0 && !v.glitch) rxIn = 1'b1;
            if (k == 1) rxIn = 1'b1;
            tick();
        end
    endtask

    localparam logic [9:0] IdleOuts = 10'b0100000000;

    int  nDeser, firstDeser, lastDeser, validOff, nValid, nPar, nStp;
    int  p;
    int  t1;
    int  found;
    int  validSeen;
    vec_t flagFrame;

    initial begin
        // P, parEn, glitch, parErr, stpErr, deser, validOff, parChk, stpChk, parFlag, stpFlag
        vecs[0] = '{6'd8,  1'b0, 1'b0, 1'b0, 1'b0, 8, 80,  0,  8,  0, 0};
        vecs[1] = '{6'd8,  1'b0, 1'b1, 1'b0, 1'b0, 0, -1,  0,  0,  0, 0};
        vecs[2] = '{6'd16, 1'b1, 1'b0, 1'b1, 1'b0, 8, -1,  16, 16, 1, 0};
        vecs[3] = '{6'd16, 1'b1, 1'b0, 1'b0, 1'b0, 8, 176, 16, 16, 0, 0};
        vecs[4] = '{6'd32, 1'b0, 1'b0, 1'b0, 1'b1, 8, -1,  0,  32, 0, 1};
        vecs[5] = '{6'd32, 1'b1, 1'b0, 1'b0, 1'b0, 8, 352, 32, 32, 0, 0};
        vecs[6] = '{6'd8,  1'b1, 1'b0, 1'b1, 1'b1, 8, -1,  8,  8,  1, 1};
        vecs[7] = '{6'd8,  1'b0, 1'b1, 1'b0, 1'b0, 0, -1,  0,  0,  1, 1};

        RST = 1'b0;
        applyStimulus(1'b1, 1'b0, 6'd8, 1'b0, 1'b0, 1'b0);

        // Reset held with a toggling line keeps the FSM in IDLE.
        for (int i = 0; i < 4; i++) begin
            rxIn = ~rxIn;
            tick();
            checkOutput("reset_hold_outputs", int'(outVec()), int'(IdleOuts));
        end
        rxIn = 1'b1;
        RST  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput("post_reset_idle", int'(outVec()), int'(IdleOuts));
        end

        for (int i = 0; i < 8; i++) begin
            runFrame(vecs[i], nDeser, firstDeser, lastDeser, validOff, nValid, nPar, nStp);
            p = int'(vecs[i].prescale);
            $display("[TB] vector %0d prescale=%0d", i, p);
            checkOutput("deser_count", nDeser, vecs[i].expDeser);
            if (vecs[i].expDeser > 0) begin
                checkOutput("deser_first_offset", firstDeser, 2 * p - 1);
                checkOutput("deser_last_offset", lastDeser, 9 * p - 1);
            end
            checkOutput("valid_offset", validOff, vecs[i].expValidOff);
            checkOutput("valid_count", nValid, (vecs[i].expValidOff >= 0) ? 1 : 0);
            checkOutput("par_chk_cycles", nPar, vecs[i].expParChk);
            checkOutput("stp_chk_cycles", nStp, vecs[i].expStpChk);
            checkOutput("par_err_flag", int'(par_err_flag), vecs[i].expParFlag);
            checkOutput("stp_err_flag", int'(stp_err_flag), vecs[i].expStpFlag);
            checkOutput("idle_after_frame", int'(reset_counters), 1);
        end

        // Parity error flag survives into the next frame until START->DATA.
        runFrame(vecs[2], nDeser, firstDeser, lastDeser, validOff, nValid, nPar, nStp);
        checkOutput("flag_set_before_next", int'(par_err_flag), 1);
        flagFrame = vecs[3];
        applyStimulus(1'b0, flagFrame.parEn, flagFrame.prescale, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("flag_held_in_start", int'(par_err_flag), 1);
        checkOutput("start_entered", int'(strt_chk_en), 1);
        rxIn = 1'b1;
        repeat (15) tick();
        checkOutput("flag_held_last_start", int'(par_err_flag), 1);
        tick();
        checkOutput("flag_cleared_in_data", int'(par_err_flag), 0);
        validSeen = 0;
        for (int k = 0; k < 200; k++) begin
            if (data_valid) validSeen++;
            tick();
        end
        checkOutput("flag_frame_valid", validSeen, 1);

        // Back-to-back frames: restart from VALID.
        applyStimulus(1'b0, 1'b0, 6'd8, 1'b0, 1'b0, 1'b0);
        tick();
        t1 = cyc;
        rxIn = 1'b1;
        found = 0;
        for (int k = 0; k < 200; k++) begin
            if (data_valid) begin
                found = 1;
                break;
            end
            tick();
        end
        checkOutput("b2b_first_valid_found", found, 1);
        checkOutput("b2b_first_valid_offset", cyc - t1, 80);
        t1   = cyc;
        rxIn = 1'b0;
        tick();
        checkOutput("b2b_restart_start", int'(strt_chk_en), 1);
        checkOutput("b2b_valid_one_cycle", int'(data_valid), 0);
        checkOutput("b2b_counter_cleared", int'(edgeCnt), 0);
        rxIn  = 1'b1;
        found = 0;
        for (int k = 0; k < 200; k++) begin
            if (data_valid) begin
                found = 1;
                break;
            end
            tick();
        end
        checkOutput("b2b_second_valid_found", found, 1);
        checkOutput("b2b_valid_spacing", cyc - t1, 81);
        tick();
        checkOutput("b2b_back_to_idle", int'(outVec()), int'(IdleOuts));

        // Asynchronous reset in the middle of DATA drops the frame.
        applyStimulus(1'b0, 1'b0, 6'd8, 1'b0, 1'b0, 1'b0);
        tick();
        rxIn = 1'b1;
        repeat (30) tick();
        checkOutput("mid_data_state", int'({cnt_enable, strt_chk_en, stp_chk_en}), 4);
        #2;
        RST = 1'b0;
        #1;
        checkOutput("async_reset_outputs", int'(outVec()), int'(IdleOuts));
        tick();
        tick();
        RST = 1'b1;
        validSeen = 0;
        for (int k = 0; k < 100; k++) begin
            if (data_valid) validSeen++;
            tick();
        end
        checkOutput("no_valid_after_reset", validSeen, 0);
        checkOutput("idle_after_reset", int'(outVec()), int'(IdleOuts));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_fsm.md
# uart_rx_fsm

Control state machine of the UART receiver. It watches the serial line for a start bit, then sequences one frame (start, 8 data bits, optional parity, stop) using the bit and edge counts from the receiver's edge/bit counter. It drives the counter enable/clear, the sampler, deserializer and checker enables, and `data_valid`. It sits between the RX pin and the counter, sampler, deserializer and checker datapath.

## Interface
- `DATA_WIDTH`, default 8: number of data bits per frame. Must be 8 or fewer so the bit count fits in 4 bits.
- `CLK`  in  1  oversampling clock.
- `RST`  in  1  reset, asynchronous, active-low.
- `RX_IN`  in  1  serial line; idles high.
- `PAR_EN`  in  1  1 = the frame carries a parity bit.
- `prescale`  in  6  edges per bit: 8, 16 or 32. Held constant during a frame.
- `bit_cnt`  in  4  from the counter. 0 = start bit, 1..8 = data bits, 9 = parity or stop, 10 = stop.
- `edge_cnt`  in  6  from the counter, 0..prescale-1.
- `strt_glitch`  in  1  from the start checker: sampled start bit was 1.
- `par_err`  in  1  from the parity checker.
- `stp_err`  in  1  from the stop checker: sampled stop bit was 0.
- `cnt_enable`  out  1  counter enable.
- `reset_counters`  out  1  synchronous clear of the counters.
- `dat_samp_en`  out  1  sampler enable.
- `deser_en`  out  1  one-cycle shift strobe to the deserializer.
- `strt_chk_en`, `par_chk_en`, `stp_chk_en`  out  1 each  checker enables.
- `data_valid`  out  1  one-cycle pulse: the deserializer holds a good byte.
- `par_err_flag`, `stp_err_flag`  out  1 each  sticky error flags for the last frame.

## Operation
- Six states: IDLE, START, DATA, PARITY, STOP, VALID. Encoding is free.
- `last_edge` = (`edge_cnt` == `prescale` − 1).
- Outputs decode combinationally from the state and `last_edge`, except the two error flags, which are registers.

Per-state outputs and transitions:
- **IDLE.** `reset_counters`=1; all other outputs 0. `RX_IN`==0 → START.
- **START.** `cnt_enable`, `dat_samp_en`, `strt_chk_en` = 1. On `last_edge`:
  - `strt_glitch`=1 → IDLE;
  - otherwise → DATA, and both error flags clear to 0.
- **DATA.** `cnt_enable`, `dat_samp_en` = 1; `deser_en` = `last_edge`. On `last_edge` with `bit_cnt`==`DATA_WIDTH`:
  - → PARITY if `PAR_EN`=1, else → STOP.
- **PARITY.** `cnt_enable`, `dat_samp_en`, `par_chk_en` = 1. On `last_edge`:
  - `par_err_flag` ← `par_err`;
  - → STOP (always; a parity error does not abort the frame).
- **STOP.** `cnt_enable`, `dat_samp_en`, `stp_chk_en` = 1. On `last_edge`:
  - `stp_err_flag` ← `stp_err`;
  - if `stp_err`=1 or `par_err_flag`=1 → IDLE;
  - otherwise → VALID.
- **VALID.** `data_valid`=1 and `reset_counters`=1.
  - `RX_IN`==0 → START (back-to-back frames);
  - otherwise → IDLE.

Rules:
- `PAR_EN` is sampled only at the DATA exit; a change mid-frame has no effect on the current frame.
- Error flags hold their value through IDLE and clear only on the START→DATA transition.
- The block never observes `edge_cnt` beyond `prescale` − 1. If that happens, the block waits; no recovery is required.

## Timing
- During reset and immediately after reset release:
  - state = IDLE;
  - `reset_counters`=1;
  - all other outputs, including both flags, are 0.
- Transitions take effect on the rising edge of `CLK`.
- START is entered the cycle after `RX_IN` is first seen low. The counters read 0 in the first START cycle.
- Each bit occupies exactly `prescale` cycles in its state.
  - Frame without parity: 10·`prescale` cycles from START entry to VALID.
  - Frame with parity: 11·`prescale` cycles.
- `deser_en` pulses `DATA_WIDTH` times, `prescale` cycles apart. The first pulse is in the last cycle of data bit 1.
- `data_valid` is high for exactly one cycle.
- Reset asserted mid-frame → IDLE immediately (asynchronous); no `data_valid` is produced.

## Test plan
- Reset: hold `RST`=0 with `RX_IN` toggling → `reset_counters`=1, all other outputs 0. After release the state stays IDLE while `RX_IN`=1.
- Clean frame, `prescale`=8, `PAR_EN`=0, byte 0xA5 → `deser_en` pulses 8 times at 8-cycle spacing. `data_valid` pulses once, 80 cycles after START entry. Both flags = 0.
- Start glitch, `prescale`=8: `RX_IN` low for 2 cycles only, `strt_glitch`=1 at `last_edge` → IDLE after 8 cycles; no `deser_en`, no `data_valid`.
- Parity error, `prescale`=16, `PAR_EN`=1, `par_err`=1 → STOP is still visited for 16 cycles; no `data_valid`; `par_err_flag`=1 until the next frame's START→DATA.
- Stop error, `prescale`=32, `stp_err`=1 → `stp_err_flag`=1, return to IDLE, no `data_valid`.
- Back-to-back frames: `RX_IN`=0 during VALID → START next cycle with counters at 0; the second byte yields a second `data_valid` exactly 10·`prescale`+1 cycles after the first. Asserting `RST` midway through the DATA state suppresses the pending `data_valid`.
